vol_est: RTL and testbench

- Consumes windowed statistics from the SMA and second-moment blocks: mean E[x] and mean-of-squares E[x^2].
- Reverses the squaring: computes variance = E[x^2] - E[x]^2, then its integer square root (standard deviation / volatility).
- Multi-cycle, digit-by-digit sqrt engine with valid/ready handshakes on both sides.
- Feeds the strategy/threshold logic downstream.

---
 rtl/vol_pkg.sv | 37 +++
 rtl/isqrt_seq.sv | 81 ++++++++
 rtl/vol_est.sv | 144 ++++++++++++++
 tb/tb_vol_est.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vol_pkg
//  Description : Shared types and width helpers for the volatility estimator
//                (vol_est) and its sequential integer square-root engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package vol_pkg;

    // Handshake/compute FSM states of vol_est
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } vol_state_t;

    // Default price-sample width
    localparam int DEF_DATA_WIDTH = 8;

    // Variance / second-moment width
    function automatic int var_w(input int dw);
        return 2 * dw;
    endfunction

    // Partial remainder width: two guard bits keep the trial subtract exact
    function automatic int rem_w(input int dw);
        return dw + 2;
    endfunction

    // Iteration counter width (at least one bit)
    function automatic int cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage : vol_pkg
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq
//  Description : Restoring digit-by-digit integer square root. One result
//                bit per cycle, MSB first; DATA_WIDTH cycles per operation.
//                done pulses for one cycle once root/rem are final.
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_seq
    import vol_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int VAR_W      = var_w(DATA_WIDTH),
    localparam int REM_W      = rem_w(DATA_WIDTH),
    localparam int CNT_W      = cnt_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VAR_W-1:0]      radicand,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] root,
    output logic [REM_W-1:0]      rem
);

    logic [VAR_W-1:0]      r_rad;
    logic [REM_W-1:0]      r_rem;
    logic [DATA_WIDTH-1:0] r_root;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic [REM_W-1:0]      w_trial_rem;
    logic [REM_W-1:0]      w_trial_sub;
    logic [REM_W-1:0]      w_diff;
    logic                  w_fits;

    // Bring down the next two radicand bits and test (root<<2 | 1)
    assign w_trial_rem = {r_rem[REM_W-3:0], r_rad[VAR_W-1 -: 2]};
    assign w_trial_sub = {r_root, 2'b01};
    assign w_diff      = w_trial_rem - w_trial_sub;
    assign w_fits      = (w_trial_rem >= w_trial_sub);

    // Load on start, then resolve one root bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rad  <= radicand;
                r_rem  <= '0;
                r_root <= '0;
                r_cnt  <= CNT_W'(DATA_WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rad  <= {r_rad[VAR_W-3:0], 2'b00};
                r_rem  <= w_fits ? w_diff : w_trial_rem;
                r_root <= {r_root[DATA_WIDTH-2:0], w_fits};
                r_cnt  <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign root = r_root;
    assign rem  = r_rem;

endmodule : isqrt_seq
`default_nettype wire

// File: rtl/vol_est.sv
`default_nettype none
// ============================================================================
//  Module      : vol_est
//  Description : Volatility estimator. Takes windowed E[x] and E[x^2],
//                forms variance = E[x^2] - E[x]^2 (clamped at zero) and its
//                integer square root, with valid/ready on both sides.
//                Optional macro VOL_ROUND_EN: round std_out to nearest
//                (saturating) instead of flooring.
//  Revision    : 1.0 - initial release
// ============================================================================
module vol_est
    import vol_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int VAR_W      = var_w(DATA_WIDTH),
    localparam int REM_W      = rem_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mean_in,
    input  logic [VAR_W-1:0]      sec_mom_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [VAR_W-1:0]      var_out,
    output logic [DATA_WIDTH-1:0] std_out
);

    vol_state_t            r_state;
    vol_state_t            w_state_next;

    logic [DATA_WIDTH-1:0] r_mean;
    logic [VAR_W-1:0]      r_sec;
    logic [VAR_W-1:0]      r_var;
    logic [DATA_WIDTH-1:0] r_std;

    logic [VAR_W-1:0]      w_sq;
    logic [VAR_W-1:0]      w_var;
    logic                  w_start;
    logic                  w_eng_busy;
    logic                  w_eng_done;
    logic [DATA_WIDTH-1:0] w_root;
    logic [REM_W-1:0]      w_rem;
    logic [DATA_WIDTH-1:0] w_std_next;

    // Clamp absorbs truncation in the upstream averages (E[x]^2 may exceed E[x^2])
    assign w_sq    = VAR_W'(r_mean) * VAR_W'(r_mean);
    assign w_var   = (r_sec >= w_sq) ? (r_sec - w_sq) : '0;
    assign w_start = (r_state == SUB);

`ifdef VOL_ROUND_EN
    // Round up when the leftover exceeds root; hold at full scale on overflow
    assign w_std_next = (w_rem > {2'b00, w_root})
                      ? ((w_root == '1) ? w_root : w_root + 1'b1)
                      : w_root;
    logic w_unused_busy;
    assign w_unused_busy = w_eng_busy;
`else
    assign w_std_next = w_root;
    logic w_unused_eng;
    assign w_unused_eng = w_eng_busy ^ (^w_rem);
`endif

    isqrt_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .radicand (w_var),
        .busy     (w_eng_busy),
        .done     (w_eng_done),
        .root     (w_root),
        .rem      (w_rem)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = SUB;
                end
            end
            SUB: begin
                w_state_next = ROOT;
            end
            ROOT: begin
                if (w_eng_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, variance and final root registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mean <= '0;
            r_sec  <= '0;
            r_var  <= '0;
            r_std  <= '0;
        end else begin
            if ((r_state == IDLE) && in_valid) begin
                r_mean <= mean_in;
                r_sec  <= sec_mom_in;
            end
            if (r_state == SUB) begin
                r_var <= w_var;
            end
            if ((r_state == ROOT) && w_eng_done) begin
                r_std <= w_std_next;
            end
        end
    end

    assign var_out = r_var;
    assign std_out = r_std;

endmodule : vol_est
`default_nettype wire

// File: tb/tb_vol_est.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vol_est
//  Description : Self-checking bench for vol_est (DATA_WIDTH = 8): directed
//                boundary cases, backpressure, mid-operation reset and
//                randomized pairs against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vol_est;

    localparam int DW  = 8;
    localparam int LAT = DW + 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] mean_in;
    logic [2*DW-1:0] sec_mom_in;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic [2*DW-1:0] var_out;
    logic [DW-1:0] std_out;

    int n_checks = 0;
    int n_fail   = 0;

    vol_est #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mean_in    (mean_in),
        .sec_mom_in (sec_mom_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .var_out    (var_out),
        .std_out    (std_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: clamped variance, then the largest r with r*r <= var
    function automatic void ref_model(input int m, input int s, output int v, output int sd);
        int r;
        v = (s >= m * m) ? (s - m * m) : 0;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
`ifdef VOL_ROUND_EN
        if (v - r * r > r) r = (r == 255) ? 255 : r + 1;
`endif
        sd = r;
    endfunction

    // One transaction; called at #1 after an edge with the DUT idle
    task automatic run_txn(input int m, input int s, input int hold);
        int ev, es, lat;
        ref_model(m, s, ev, es);
        mean_in    = m[DW-1:0];
        sec_mom_in = s[2*DW-1:0];
        in_valid   = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, LAT);
        check("var_out", var_out, ev);
        check("std_out", std_out, es);
        for (int h = 0; h < hold; h++) begin
            check("in_ready_busy", in_ready, 0);
            in_valid   = $urandom_range(0, 1);
            mean_in    = DW'($urandom);
            sec_mom_in = 16'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_var", var_out, ev);
            check("hold_std", std_out, es);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, s, stale;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        mean_in    = '0;
        sec_mom_in = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_var", var_out, 0);
        check("rst_std", std_out, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_txn(10, 116, 5);
        run_txn(11, 116, 0);
        run_txn(0, 65535, 1);
        run_txn(0, 21, 0);
        run_txn(0, 20, 0);
        run_txn(15, 225, 0);
        run_txn(255, 65535, 0);

        // Reset during the root iterations
        mean_in    = 50;
        sec_mom_in = 3000;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_var", var_out, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        check("no_stale_result", stale, 0);
        run_txn(2, 8, 0);

        // Randomized pairs
        for (int t = 0; t < 24; t++) begin
            m = $urandom_range(0, 255);
            if (t % 2 == 0) begin
                s = m * m + $urandom_range(0, 700);
                if (s > 65535) s = 65535;
            end else begin
                s = $urandom_range(0, 65535);
            end
            run_txn(m, s, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vol_est
`default_nettype wire
